// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: funct3 widths, FSM states and
// the lane-alignment helpers used by both the control path and mem_align.
package mem_access_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] selects the access size; reserved codes fall into the word case
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Byte lane actually used once misaligned low address bits are forced to 0
   function automatic logic [1:0] lane_align(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         SZ_B:    return addr_lo;
         SZ_H:    return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         default: return addr_lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replicated data and load extraction with
// sign or zero extension.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
   assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

   always_comb begin
      o_wstrb     = 4'b1111;
      o_wdata     = i_store_data;
      o_load_data = i_rdata;
      case (i_funct3[1:0])
         SZ_B: begin
            o_wstrb     = 4'b0001 << i_lane;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            o_wstrb     = 4'b0011 << {i_lane[1], 1'b0};
            o_wdata     = {2{i_store_data[15:0]}};
            o_load_data = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: one instruction per cycle from execute, blocking data-memory
// handshake. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic              ex_is_store,
   input  logic [2:0]        ex_funct3,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [WIDTH-1:0]  ex_store_data,
   input  logic [REG_W-1:0]  ex_rd_sel,
   input  logic [WIDTH-1:0]  ex_result,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [WIDTH-1:0]  dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_ready,
   input  logic [WIDTH-1:0]  dmem_rdata,
   output logic [REG_W-1:0]  rd_mem_sel,
   output logic [WIDTH-1:0]  rd_mem
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_trap,
   output logic [ADDR_W-1:0] trap_addr
`endif
);

   state_t             r_state;
   logic               r_we;
   logic [ADDR_W-1:2]  r_addr;
   logic [1:0]         r_lane;
   logic [2:0]         r_funct3;
   logic [WIDTH-1:0]   r_store_data;
   logic [REG_W-1:0]   r_rd_cap;
   logic [REG_W-1:0]   r_rd_mem_sel;
   logic [WIDTH-1:0]   r_rd_mem;

   state_t             w_state_d;
   logic               w_accept;
   logic               w_done;
   logic               w_is_mem;
   logic               w_misalign;
   logic [3:0]         w_wstrb;
   logic [WIDTH-1:0]   w_wdata;
   logic [WIDTH-1:0]   w_load_data;

   assign w_is_mem = ex_is_load | ex_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   logic              r_trap;
   logic [ADDR_W-1:0] r_trap_addr;

   assign w_misalign    = is_misaligned(ex_funct3, ex_addr[1:0]);
   assign misalign_trap = r_trap;
   assign trap_addr     = r_trap_addr;
`else
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (ex_valid && w_is_mem && !w_misalign) begin
               w_accept  = 1'b1;
               w_state_d = BUSY;
            end
         end
         BUSY: begin
            if (dmem_ready) begin
               w_done    = 1'b1;
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_lane       <= '0;
         r_funct3     <= '0;
         r_store_data <= '0;
         r_rd_cap     <= '0;
         r_rd_mem_sel <= '0;
         r_rd_mem     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         r_trap       <= 1'b0;
         r_trap_addr  <= '0;
`endif
      end else if (!halt) begin
         r_state      <= w_state_d;
         r_rd_mem_sel <= '0;
         if (r_state == IDLE && ex_valid && !w_is_mem) begin
            r_rd_mem_sel <= ex_rd_sel;
            r_rd_mem     <= ex_result;
         end
         if (w_accept) begin
            r_we         <= ex_is_store;
            r_addr       <= ex_addr[ADDR_W-1:2];
            r_lane       <= lane_align(ex_funct3, ex_addr[1:0]);
            r_funct3     <= ex_funct3;
            r_store_data <= ex_store_data;
            r_rd_cap     <= ex_rd_sel;
         end
         if (w_done && !r_we) begin
            r_rd_mem_sel <= r_rd_cap;
            r_rd_mem     <= w_load_data;
         end
`ifdef MEM_MISALIGN_TRAP_EN
         r_trap <= (r_state == IDLE) && ex_valid && w_is_mem && w_misalign;
         if ((r_state == IDLE) && ex_valid && w_is_mem && w_misalign) begin
            r_trap_addr <= ex_addr;
         end
`endif
      end
   end

   mem_align u_mem_align (
      .i_funct3     (r_funct3),
      .i_lane       (r_lane),
      .i_store_data (r_store_data),
      .i_rdata      (dmem_rdata),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   // Request fields are gated so the bus reads all-zero whenever no request is in flight
   assign stall      = (r_state == BUSY);
   assign dmem_req   = stall;
   assign dmem_we    = stall & r_we;
   assign dmem_addr  = stall ? {r_addr, 2'b00} : '0;
   assign dmem_wdata = (stall && r_we) ? w_wdata : '0;
   assign dmem_wstrb = (stall && r_we) ? w_wstrb : '0;
   assign rd_mem_sel = r_rd_mem_sel;
   assign rd_mem     = r_rd_mem;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage of the 5-stage RV32I pipeline, between execute and the register-file/write-back block.
- Accepts one instruction per cycle from execute.
- Issues loads and stores to data memory over a valid/ready handshake.
- Aligns and sign- or zero-extends load data.
- Presents the retiring destination register (rd_mem_sel, rd_mem) to write-back and operand forwarding.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
WIDTH, 32, datapath and memory data width; only 32 is supported.
ADDR_W, 32, data memory byte-address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
halt  in  1  freezes all state while 1
ex_valid  in  1  execute stage presents an instruction
ex_is_load  in  1  instruction is a load
ex_is_store  in  1  instruction is a store
ex_funct3  in  3  RV32I load/store width field
ex_addr  in  ADDR_W  effective byte address
ex_store_data  in  WIDTH  rs2 value for stores
ex_rd_sel  in  5  destination register
ex_result  in  WIDTH  ALU result for non-memory instructions
stall  out  1  upstream must hold ex_* stable
dmem_req  out  1  request valid
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits = 0)
dmem_wdata  out  WIDTH  lane-replicated store data
dmem_wstrb  out  4  byte write enables
dmem_ready  in  1  memory accepts/completes the request this cycle
dmem_rdata  in  WIDTH  read data, valid when dmem_ready is 1 and dmem_we is 0
rd_mem_sel  out  5  retiring destination register; 0 = bubble
rd_mem  out  WIDTH  retiring value

Behaviour:
- FSM has two states, IDLE and BUSY. Reset forces IDLE and sets every output to 0. A request in flight is abandoned: dmem_req falls on the cycle after reset is sampled.
- stall = (state == BUSY), combinational. Inputs on ex_* are ignored while BUSY.
- IDLE, ex_valid with neither ex_is_load nor ex_is_store: rd_mem_sel/rd_mem <= ex_rd_sel/ex_result (1-cycle latency).
- IDLE, load or store: capture the request fields, go to BUSY, and set rd_mem_sel <= 0.
- IDLE, ex_valid = 0: rd_mem_sel <= 0.
- BUSY: dmem_req = 1, and dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held constant until dmem_ready is 1. With a zero-wait memory, ready can arrive in the first BUSY cycle.
- On dmem_ready in BUSY: return to IDLE.
  - Load: rd_mem_sel <= captured rd, rd_mem <= extended data.
  - Store: rd_mem_sel <= 0.
  - Earliest retirement of a load is 2 cycles after acceptance.
- rd_mem_sel is 0 in every cycle that is not a retirement.
- Load extraction uses byte lane addr[1:0] and half lane addr[1]:
  - LB = 000, LBU = 100: byte, sign- or zero-extended.
  - LH = 001, LHU = 101: half, sign- or zero-extended.
  - LW = 010: full word.
  - Reserved funct3 (011, 110, 111) behaves as LW/SW.
- Stores:
  - SB: wstrb = 0001 << addr[1:0], wdata = byte replicated ×4.
  - SH: wstrb = 0011 << {addr[1],0}, wdata = half replicated ×2.
  - SW: wstrb = 1111.
  - For loads, dmem_wstrb = 0000.
- Misaligned accesses (SH/LH with addr[0] = 1; word accesses with addr[1:0] ≠ 0) have the offending low bits forced to 0, unless the optional feature is enabled.
- halt = 1: no state change, outputs hold, and dmem_req stays asserted if BUSY. A dmem_ready arriving during halt is ignored, so the memory must hold the response until halt drops.
- ex_rd_sel = 0 on a load: the transaction still occurs and the retirement carries rd_mem_sel = 0.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Enabled: adds outputs misalign_trap (1 bit) and trap_addr (ADDR_W).
  - A misaligned load/store in IDLE issues no dmem_req and stays in IDLE.
  - misalign_trap = 1 for the following cycle, with trap_addr = ex_addr.
  - rd_mem_sel = 0 for that cycle.
  - Both ports reset to 0.
- Disabled: the ports are absent and forced alignment applies.

Decomposition:
- Shared package:
  - funct3 load/store encodings.
  - FSM state encoding (IDLE = 0, BUSY = 1).
  - Register-index width constant (5).
- One sub-module, mem_align: purely combinational.
  - Store path: funct3 + addr[1:0] + data → wstrb/wdata.
  - Load path: funct3 + addr[1:0] + rdata → extended result.
  - Instanced once and unit-testable alone.

Test Plan:
1. ALU pass-through: ex_valid = 1, rd = 5, result = 0x1234 → next cycle rd_mem_sel = 5, rd_mem = 0x1234, stall = 0.
2. LB, zero-wait: addr 0x103, rdata 0x80FF_0000 with ready in the first BUSY cycle → dmem_addr = 0x100, wstrb = 0; one cycle later rd_mem = 0xFFFF_FF80.
3. SH with 3 wait cycles: addr 0x202, data 0x0000_BEEF → wstrb = 1100, wdata = 0xBEEF_BEEF, request held stable for 4 cycles, stall = 1 throughout, rd_mem_sel = 0.
4. LHU addr 0x6, rdata 0xA5A5_0000 → rd_mem = 0x0000_A5A5. Back-to-back: an ALU op presented during BUSY retires exactly one cycle after the load retires.
5. Reset asserted mid-BUSY → dmem_req = 0 and stall = 0 the next cycle; a late dmem_ready produces no retirement. halt during BUSY with ready = 1 → no retirement until halt drops.
6. Feature enabled: LW at 0x102 → no dmem_req; misalign_trap = 1 and trap_addr = 0x102 for one cycle.
